agdc_input_conditioner: RTL
===========================

Name: agdc_input_conditioner

Overview:
Front-end stage feeding the garage door controller FSM. Synchronises and debounces the raw Activate push-button and the UP_Max/DN_Max limit switches. Converts each debounced Activate press into a single-cycle request pulse. The controller's Activate, UP_Max and DN_Max inputs connect directly to Act_Pulse, UP_Max_db and DN_Max_db.

Parameters:
DB_CYCLES, 16, consecutive cycles a synchronised level must hold before the debounced output follows it (legal range 2..2^CNT_W-1)
CNT_W, 5, width of each debounce counter and of the ready counter

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous active-low reset
Activate_raw  input  1  raw push-button, asynchronous, bouncy
UP_Max_raw  input  1  raw upper limit switch, asynchronous, bouncy
DN_Max_raw  input  1  raw lower limit switch, asynchronous, bouncy
Act_Pulse  output  1  one-cycle request pulse per debounced press
UP_Max_db  output  1  debounced upper limit level
DN_Max_db  output  1  debounced lower limit level
Ready  output  1  high once the initial debounce window after reset has elapsed
Sensor_Fault  output  1  both limits active at once (see Optional Feature)

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (RST). While RST=0, every flop clears immediately, independent of CLK. This covers both synchroniser stages, all debounce counters, the debounced levels, the ready counter, Act_Pulse, Ready and Sensor_Fault. All outputs read 0 during reset.
- Synchroniser: each raw input passes through a 2-flop synchroniser. The output of the second flop is "sync".
- Debouncer, one per input, each an independent CNT_W-bit counter:
  - If sync equals db, the counter clears to 0.
  - If sync differs from db and counter < DB_CYCLES-1, the counter increments.
  - If sync differs from db and counter = DB_CYCLES-1, db takes the value of sync and the counter clears.
- Debounce latency: a raw level first sampled at edge N reaches db at edge N+1+DB_CYCLES, provided it holds throughout.
- Glitch rejection: any excursion at sync shorter than DB_CYCLES cycles is rejected, and the counter restarts from 0 on each return.
- Pulse generator:
  - Act_Pulse is registered. It is 1 in the cycle after the edge at which Activate db rises 0->1, and 0 otherwise.
  - A held button produces exactly one pulse.
  - Release (1->0) produces no pulse.
  - Act_Pulse is never high for two consecutive cycles.
- Ready:
  - A CNT_W-bit counter starts at 0 on reset release and increments each cycle.
  - It saturates, and Ready is set to 1, when the count reaches DB_CYCLES+2.
  - Ready stays 1 until the next reset.
- Gating while not ready:
  - While Ready=0, Act_Pulse is forced to 0.
  - A press whose debounced rise happens before Ready never generates a pulse later.
  - UP_Max_db and DN_Max_db are not gated.
- Simultaneous events: the three channels are fully independent. Bounce on one channel never affects another channel's counter.
- Reset mid-operation: a partially counted debounce is discarded. After release, the input must hold for the full DB_CYCLES again.
- No parameter-dependent width growth; the counters never wrap.

Optional Feature:
Macro: AGDC_COND_FAULT_EN
- Defined:
  - Sensor_Fault latches to 1 on the edge after UP_Max_db and DN_Max_db are both 1 in the same cycle.
  - It stays 1 until RST=0, and while it is 1, Act_Pulse is forced to 0.
  - This keeps the downstream FSM idle when a limit switch is stuck.
- Not defined: Sensor_Fault is tied to 0, no fault logic is generated, and Act_Pulse is gated by Ready only.

Test Plan:
1. Reset held 5 cycles, then released, DB_CYCLES=16 → all outputs 0 during reset. Ready rises 18 cycles after the first post-reset edge.
2. After Ready, Activate_raw toggles 1/0 every 3 cycles for 30 cycles, then holds 1 for 40 cycles → no pulse during bounce. Exactly one Act_Pulse occurs, 17 edges after the stable level is first sampled.
3. Activate_raw held 1 for 100 cycles, released, and pressed again → exactly 2 pulses in total. No pulse on release.
4. DN_Max_raw goes high for 15 cycles, then low → DN_Max_db stays 0. The same input held for 16 cycles → DN_Max_db becomes 1.
5. RST asserted mid-count (counter at 10) on UP_Max → UP_Max_db stays 0. After release, a full 16-cycle hold is required.
6. With AGDC_COND_FAULT_EN defined, both raw limits are driven high, then Activate is pressed → Sensor_Fault=1 and no Act_Pulse. Only RST clears the fault. Without the macro, Sensor_Fault stays 0 and the pulse appears.

Source files
------------

// File: rtl/agdc_input_conditioner.sv
// Input conditioner for the garage door controller: 2-flop sync, debounce, press-to-pulse, ready timer.
// Optional stuck-limit detection is built when AGDC_COND_FAULT_EN is defined.
module agdc_input_conditioner #(
   parameter int unsigned DB_CYCLES = 16,
   parameter int unsigned CNT_W     = 5
) (
   input  logic CLK,
   input  logic RST,
   input  logic Activate_raw,
   input  logic UP_Max_raw,
   input  logic DN_Max_raw,
   output logic Act_Pulse,
   output logic UP_Max_db,
   output logic DN_Max_db,
   output logic Ready,
   output logic Sensor_Fault
);

   localparam int unsigned NCH     = 3;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
   localparam int unsigned RDY_TGT = ((DB_CYCLES + 2) > CNT_MAX) ? CNT_MAX : (DB_CYCLES + 2);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] RDY_END = CNT_W'(RDY_TGT);

   // Channel order: [0] Activate, [1] UP_Max, [2] DN_Max
   logic [NCH-1:0]            raw_c;
   logic [NCH-1:0]            sync1;
   logic [NCH-1:0]            sync2;
   logic [NCH-1:0]            db;
   logic [NCH-1:0]            db_nxt_c;
   logic [NCH-1:0][CNT_W-1:0] cnt;
   logic [NCH-1:0][CNT_W-1:0] cnt_nxt_c;
   logic [CNT_W-1:0]          rdy_cnt;
   logic                      act_rise_c;
   logic                      pulse_ok_c;

   assign raw_c = {DN_Max_raw, UP_Max_raw, Activate_raw};

   // Per-channel debounce: db follows sync only after DB_CYCLES consecutive disagreeing cycles
   always_comb begin
      db_nxt_c  = db;
      cnt_nxt_c = cnt;
      for (int i = 0; i < NCH; i++) begin
         if (sync2[i] == db[i]) begin
            cnt_nxt_c[i] = '0;
         end else if (cnt[i] == DB_LAST) begin
            db_nxt_c[i]  = sync2[i];
            cnt_nxt_c[i] = '0;
         end else begin
            cnt_nxt_c[i] = cnt[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         cnt   <= '0;
      end else begin
         sync1 <= raw_c;
         sync2 <= sync1;
         db    <= db_nxt_c;
         cnt   <= cnt_nxt_c;
      end
   end

   assign UP_Max_db = db[1];
   assign DN_Max_db = db[2];

   // Ready timer saturates at its target and stays set until reset
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdy_cnt <= '0;
         Ready   <= 1'b0;
      end else begin
         if (rdy_cnt != RDY_END) begin
            rdy_cnt <= rdy_cnt + CNT_W'(1);
         end
         if (rdy_cnt == RDY_END) begin
            Ready <= 1'b1;
         end
      end
   end

`ifdef AGDC_COND_FAULT_EN
   // Both limits active together means a stuck switch; hold the fault until reset
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Sensor_Fault <= 1'b0;
      end else if (db[1] && db[2]) begin
         Sensor_Fault <= 1'b1;
      end
   end

   assign pulse_ok_c = Ready & ~Sensor_Fault;
`else
   assign Sensor_Fault = 1'b0;
   assign pulse_ok_c   = Ready;
`endif

   // Pulse lands in the same cycle the debounced Activate level first reads 1
   assign act_rise_c = db_nxt_c[0] & ~db[0];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Act_Pulse <= 1'b0;
      end else begin
         Act_Pulse <= act_rise_c & pulse_ok_c;
      end
   end

endmodule
